// File: rtl/assignment_sweep_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module : assignment_sweep_reader_pkg
// Brief  : Shared slot/width helpers and sweep FSM encoding.
// Rev    : 1.0
// ============================================================================
package assignment_sweep_reader_pkg;

   localparam int DEF_INT_INDEX_W  = 2;
   localparam int DEF_BOOL_INDEX_W = 2;
   localparam int DEF_INT_W        = 4;
   localparam int DEF_BOOL_W       = 2;

   function automatic int num_slots(input int index_w);
      return 1 << index_w;
   endfunction

   function automatic int flat_width(input int index_w, input int slot_w);
      return slot_w * num_slots(index_w);
   endfunction

   localparam int DEF_INT_SLOTS  = num_slots(DEF_INT_INDEX_W);
   localparam int DEF_BOOL_SLOTS = num_slots(DEF_BOOL_INDEX_W);

   typedef logic [1:0] sweep_state_t;
   localparam sweep_state_t ST_IDLE  = 2'd0;
   localparam sweep_state_t ST_SWEEP = 2'd1;
   localparam sweep_state_t ST_DONE  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/assignment_sweep_reader_slot_select.sv
`default_nettype none
// ============================================================================
// Module : assignment_slot_select
// Brief  : Combinational pick of slot[idx] from a flattened slot vector.
// Rev    : 1.0
// ============================================================================
module assignment_slot_select
   import assignment_sweep_reader_pkg::*;
#(
   parameter int SLOT_W  = DEF_INT_W,
   parameter int INDEX_W = DEF_INT_INDEX_W
) (
   input  logic [flat_width(INDEX_W, SLOT_W)-1:0] vec_i,
   input  logic [INDEX_W-1:0]                     idx_i,
   output logic [SLOT_W-1:0]                      slot_o
);

   localparam int C_SLOTS = num_slots(INDEX_W);

   logic [SLOT_W-1:0] w_slots [C_SLOTS];

   for (genvar g = 0; g < C_SLOTS; g++) begin : g_unpack
      assign w_slots[g] = vec_i[g*SLOT_W +: SLOT_W];
   end

   assign slot_o = w_slots[idx_i];

endmodule
`default_nettype wire

// File: rtl/assignment_sweep_reader.sv
`default_nettype none
// ============================================================================
// Module : assignment_sweep_reader
// Brief  : Snapshots the assignment vectors on start and streams the integer
//          slots one beat per handshake, then pulses done.
// Rev    : 1.0
// ============================================================================
module assignment_sweep_reader
   import assignment_sweep_reader_pkg::*;
#(
   parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = DEF_INT_INDEX_W,
   parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = DEF_BOOL_INDEX_W,
   parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE       = DEF_INT_W,
   parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE       = DEF_BOOL_W
) (
   input  logic clk,
   input  logic reset,
   input  logic in_start,
   input  logic [MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX:0] in_number_of_integer_variables,
   input  logic [flat_width(MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX,
                            MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE)-1:0] in_integer_assignment,
   input  logic [flat_width(MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX,
                            MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE)-1:0] in_boolean_assignment,
   input  logic in_ready,
   output logic out_valid,
   output logic [MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX-1:0] out_variable_index,
   output logic [MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0]       out_variable_value,
   output logic out_last,
   output logic [flat_width(MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX,
                            MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE)-1:0] out_boolean_assignment,
   output logic out_busy,
   output logic out_done
);

   localparam int IDX_W      = MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX;
   localparam int INT_W      = MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE;
   localparam int CNT_W      = IDX_W + 1;
   localparam int INT_VEC_W  = flat_width(IDX_W, INT_W);
   localparam int BOOL_VEC_W = flat_width(MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX,
                                          MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE);
   localparam logic [CNT_W-1:0] C_SLOTS = CNT_W'(num_slots(IDX_W));

   sweep_state_t            state_q,    state_d;
   logic [CNT_W-1:0]        index_q,    index_d;
   logic [CNT_W-1:0]        count_q,    count_d;
   logic [INT_VEC_W-1:0]    int_snap_q, int_snap_d;
   logic [BOOL_VEC_W-1:0]   bool_snap_q, bool_snap_d;

   logic [CNT_W-1:0]        w_count_clamped;
   logic                    w_last;

   // Counter math stays one bit wider than the index so count==N never wraps.
   assign w_count_clamped = (in_number_of_integer_variables > C_SLOTS)
                            ? C_SLOTS : in_number_of_integer_variables;
   assign w_last          = (index_q == count_q - CNT_W'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         index_q     <= '0;
         count_q     <= '0;
         int_snap_q  <= '0;
         bool_snap_q <= '0;
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         count_q     <= count_d;
         int_snap_q  <= int_snap_d;
         bool_snap_q <= bool_snap_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      index_d     = index_q;
      count_d     = count_q;
      int_snap_d  = int_snap_q;
      bool_snap_d = bool_snap_q;
      case (state_q)
         ST_IDLE: begin
            if (in_start) begin
               int_snap_d  = in_integer_assignment;
               bool_snap_d = in_boolean_assignment;
               count_d     = w_count_clamped;
               index_d     = '0;
               state_d     = (w_count_clamped == '0) ? ST_DONE : ST_SWEEP;
            end
         end
         ST_SWEEP: begin
            if (in_ready) begin
               if (w_last) state_d = ST_DONE;
               else        index_d = index_q + CNT_W'(1);
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      out_valid              = (state_q == ST_SWEEP);
      out_last               = (state_q == ST_SWEEP) && w_last;
      out_busy               = (state_q != ST_IDLE);
      out_done               = (state_q == ST_DONE);
      out_variable_index     = index_q[IDX_W-1:0];
      out_boolean_assignment = bool_snap_q;
   end

   assignment_slot_select #(
      .SLOT_W  (INT_W),
      .INDEX_W (IDX_W)
   ) u_slot_select (
      .vec_i  (int_snap_q),
      .idx_i  (index_q[IDX_W-1:0]),
      .slot_o (out_variable_value)
   );

endmodule
`default_nettype wire

// File: tb/tb_assignment_sweep_reader.sv
`default_nettype none
// ============================================================================
// Module : tb_assignment_sweep_reader
// Brief  : Directed self-checking bench for assignment_sweep_reader.
// Rev    : 1.0
// ============================================================================
module tb_assignment_sweep_reader;

   logic        clk;
   logic        reset;
   logic        in_start;
   logic [2:0]  in_number_of_integer_variables;
   logic [15:0] in_integer_assignment;
   logic [7:0]  in_boolean_assignment;
   logic        in_ready;
   logic        out_valid;
   logic [1:0]  out_variable_index;
   logic [3:0]  out_variable_value;
   logic        out_last;
   logic [7:0]  out_boolean_assignment;
   logic        out_busy;
   logic        out_done;

   int errors = 0;
   int checks = 0;

   // Beats recorded by collect()
   int          nbeats;
   int          done_cyc;
   logic [1:0]  b_idx  [16];
   logic [3:0]  b_val  [16];
   logic        b_last [16];
   int          b_cyc  [16];

   // Hand-decoded slots of 16'hF3A5: 5, -6, 3, -1
   logic [3:0]  exp_val [4] = '{4'h5, 4'hA, 4'h3, 4'hF};

   assignment_sweep_reader dut (
      .clk                            (clk),
      .reset                          (reset),
      .in_start                       (in_start),
      .in_number_of_integer_variables (in_number_of_integer_variables),
      .in_integer_assignment          (in_integer_assignment),
      .in_boolean_assignment          (in_boolean_assignment),
      .in_ready                       (in_ready),
      .out_valid                      (out_valid),
      .out_variable_index             (out_variable_index),
      .out_variable_value             (out_variable_value),
      .out_last                       (out_last),
      .out_boolean_assignment         (out_boolean_assignment),
      .out_busy                       (out_busy),
      .out_done                       (out_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [2:0] cnt, input logic [15:0] vec, input logic [7:0] bvec);
      in_number_of_integer_variables = cnt;
      in_integer_assignment          = vec;
      in_boolean_assignment          = bvec;
      in_start                       = 1'b1;
      tick();
      in_start                       = 1'b0;
   endtask

   // Cycle c=1 is the first cycle after the start edge.
   task automatic collect(input bit toggle, input bit scramble, input bit spam_start);
      logic       held;
      logic [1:0] h_idx;
      logic [3:0] h_val;
      logic       h_last;
      held     = 1'b0;
      h_idx    = '0;
      h_val    = '0;
      h_last   = 1'b0;
      nbeats   = 0;
      done_cyc = -1;
      for (int c = 1; c <= 40; c++) begin
         in_ready = toggle ? ((c % 2) == 0) : 1'b1;
         if (scramble) begin
            in_integer_assignment = 16'h0000;
            in_boolean_assignment = 8'h00;
         end
         if (spam_start) begin
            in_start                       = 1'b1;
            in_number_of_integer_variables = 3'd1;
         end
         if (out_done) begin
            done_cyc = c;
            break;
         end
         if (out_valid) begin
            if (held) begin
               chk("hold_idx",  {30'd0, out_variable_index}, {30'd0, h_idx});
               chk("hold_val",  {28'd0, out_variable_value}, {28'd0, h_val});
               chk("hold_last", {31'd0, out_last},           {31'd0, h_last});
            end
            if (in_ready) begin
               if (nbeats < 16) begin
                  b_idx[nbeats]  = out_variable_index;
                  b_val[nbeats]  = out_variable_value;
                  b_last[nbeats] = out_last;
                  b_cyc[nbeats]  = c;
               end
               nbeats++;
               held = 1'b0;
            end else begin
               held   = 1'b1;
               h_idx  = out_variable_index;
               h_val  = out_variable_value;
               h_last = out_last;
            end
         end
         tick();
      end
      in_start = 1'b0;
      if (done_cyc < 0) chk("done_timeout", 32'd0, 32'd1);
      tick();
      chk("done_width", {31'd0, out_done}, 32'd0);
      chk("idle_busy",  {31'd0, out_busy}, 32'd0);
   endtask

   task automatic check_beats(input int n, input bit back_to_back);
      chk("n_beats", nbeats, n);
      for (int k = 0; k < n && k < nbeats; k++) begin
         chk("beat_idx",  {30'd0, b_idx[k]},  k);
         chk("beat_val",  {28'd0, b_val[k]},  {28'd0, exp_val[k]});
         chk("beat_last", {31'd0, b_last[k]}, (k == n - 1) ? 32'd1 : 32'd0);
         if (back_to_back) chk("beat_cycle", b_cyc[k], k + 1);
      end
   endtask

   initial begin
      reset                          = 1'b1;
      in_start                       = 1'b0;
      in_number_of_integer_variables = '0;
      in_integer_assignment          = '0;
      in_boolean_assignment          = '0;
      in_ready                       = 1'b0;
      tick();
      tick();
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_last",  {31'd0, out_last},  32'd0);
      chk("rst_busy",  {31'd0, out_busy},  32'd0);
      chk("rst_done",  {31'd0, out_done},  32'd0);
      chk("rst_index", {30'd0, out_variable_index}, 32'd0);
      chk("rst_value", {28'd0, out_variable_value}, 32'd0);
      chk("rst_bool",  {24'd0, out_boolean_assignment}, 32'd0);
      reset = 1'b0;
      tick();

      // Full sweep, no backpressure
      start(3'd4, 16'hF3A5, 8'h5A);
      collect(1'b0, 1'b0, 1'b0);
      check_beats(4, 1'b1);
      chk("full_done_cyc", done_cyc, 5);

      // Backpressure: ready low on odd cycles, last accept at c=8
      start(3'd4, 16'hF3A5, 8'h5A);
      collect(1'b1, 1'b0, 1'b0);
      check_beats(4, 1'b0);
      chk("bp_done_cyc", done_cyc, 9);

      // Snapshot isolation
      start(3'd4, 16'hF3A5, 8'hC6);
      collect(1'b0, 1'b1, 1'b0);
      check_beats(4, 1'b1);
      chk("snap_bool", {24'd0, out_boolean_assignment}, 32'h0000_00C6);

      // count=0: straight to done
      start(3'd0, 16'hF3A5, 8'h11);
      collect(1'b0, 1'b0, 1'b0);
      chk("cnt0_beats", nbeats, 0);
      chk("cnt0_done_cyc", done_cyc, 1);

      // count=1
      start(3'd1, 16'hF3A5, 8'h11);
      collect(1'b0, 1'b0, 1'b0);
      check_beats(1, 1'b1);
      chk("cnt1_done_cyc", done_cyc, 2);

      // count=7 clamps to 4
      start(3'd7, 16'hF3A5, 8'h11);
      collect(1'b0, 1'b0, 1'b0);
      check_beats(4, 1'b1);

      // start held high during the sweep must not restart it
      start(3'd4, 16'hF3A5, 8'h22);
      collect(1'b1, 1'b0, 1'b1);
      check_beats(4, 1'b0);
      chk("spam_done_cyc", done_cyc, 9);

      // Start immediately after done is honoured
      in_ready = 1'b1;
      start(3'd1, 16'hF3A5, 8'h22);
      chk("restart_valid", {31'd0, out_valid}, 32'd1);
      chk("restart_last",  {31'd0, out_last},  32'd1);
      tick();
      chk("restart_done",  {31'd0, out_done},  32'd1);
      tick();

      // Reset mid-sweep after beat 1
      in_ready = 1'b1;
      start(3'd4, 16'hF3A5, 8'h33);
      tick();
      chk("pre_rst_idx", {30'd0, out_variable_index}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_busy",  {31'd0, out_busy},  32'd0);
      chk("mid_rst_done",  {31'd0, out_done},  32'd0);
      chk("mid_rst_bool",  {24'd0, out_boolean_assignment}, 32'd0);
      tick();
      chk("post_rst_done", {31'd0, out_done},  32'd0);
      start(3'd4, 16'hF3A5, 8'h33);
      collect(1'b0, 1'b0, 1'b0);
      check_beats(4, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
